// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu: load/store unit, initiator side of the DMEM port.
//   Accepts one request at a time over req_valid/req_ready, drives DMEM
//   (combinational read, write on posedge clk) from registered outputs, and
//   returns load data or a store acknowledge over resp_valid/resp_ready.
//   Misaligned half/word accesses are carried out as a sequence of byte
//   accesses (little-endian), unless LSU_MISALIGN_TRAP_EN is defined, in which
//   case they are rejected with resp_err and no DMEM side effect.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_we              1 = store, 0 = load
//   req_addr            byte address
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_signed          sign-extend byte/half loads
//   req_wdata           right-justified store data
//   resp_valid/ready    response handshake (held until accepted)
//   resp_rdata          load result, 0 for stores and errors
//   resp_err            request rejected without DMEM side effect
//   dmem_*              DMEM control/address/data (zero unless accessing)
//   dmem_read_data      DMEM combinational read data
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
// -----------------------------------------------------------------------------
module dmem_lsu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              dmem_write_en,
  output logic              dmem_sign_extend,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [1:0]        dmem_size,
  output logic [DATA_W-1:0] dmem_write_data,
  output logic [DATA_W-1:0] dmem_mem_write,
  input  logic [DATA_W-1:0] dmem_read_data
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned HALF_W = 16;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_SPLIT  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                dm_we_q, dm_we_d;
  logic                dm_sext_q, dm_sext_d;
  logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
  logic [1:0]          dm_size_q, dm_size_d;
  logic [DATA_W-1:0]   dm_wdata_q, dm_wdata_d;

  logic                req_mis_c;
  logic [IDX_W-1:0]    idx_nx_c;
  logic                split_last_c;

  // Misalignment of the incoming request; bytes are always aligned.
  assign req_mis_c = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  assign idx_nx_c     = idx_q + IDX_W'(1);
  assign split_last_c = (size_q == SZ_HALF) ? (idx_q == IDX_W'(1)) : (idx_q == IDX_W'(3));

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      idx_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_sext_q    <= 1'b0;
      dm_addr_q    <= '0;
      dm_size_q    <= '0;
      dm_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      idx_q        <= idx_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      dm_we_q      <= dm_we_d;
      dm_sext_q    <= dm_sext_d;
      dm_addr_q    <= dm_addr_d;
      dm_size_q    <= dm_size_d;
      dm_wdata_q   <= dm_wdata_d;
    end
  end

  // Next state; dmem_* are computed one cycle ahead so they appear registered
  // in exactly the ACCESS/SPLIT cycles.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    size_d       = size_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    dm_we_d      = 1'b0;
    dm_sext_d    = 1'b0;
    dm_addr_d    = '0;
    dm_size_d    = '0;
    dm_wdata_d   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d     = req_we;
          addr_d   = req_addr;
          size_d   = req_size;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          idx_d    = '0;
          rdata_d  = '0;
          err_d    = 1'b0;
          if (req_size == SZ_ILL) begin
            state_d      = ST_RESP;
            err_d        = 1'b1;
            resp_valid_d = 1'b1;
          end else if (req_mis_c) begin
`ifdef LSU_MISALIGN_TRAP_EN
            state_d      = ST_RESP;
            err_d        = 1'b1;
            resp_valid_d = 1'b1;
`else
            // First byte of the split sequence goes out next cycle.
            state_d    = ST_SPLIT;
            dm_we_d    = req_we;
            dm_addr_d  = req_addr;
            dm_size_d  = SZ_BYTE;
            dm_wdata_d = DATA_W'(req_wdata[BYTE_W-1:0]);
`endif
          end else begin
            state_d    = ST_ACCESS;
            dm_we_d    = req_we;
            dm_sext_d  = req_signed;
            dm_addr_d  = req_addr;
            dm_size_d  = req_size;
            dm_wdata_d = req_wdata;
          end
        end
      end

      ST_ACCESS: begin
        if (!we_q) begin
          rdata_d = dmem_read_data;
        end
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end

`ifndef LSU_MISALIGN_TRAP_EN
      ST_SPLIT: begin
        if (!we_q) begin
          rdata_d[{idx_q, 3'b000} +: BYTE_W] = dmem_read_data[BYTE_W-1:0];
        end
        if (split_last_c) begin
          // Upper half of a half load: sign copy or zero.
          if (!we_q && (size_q == SZ_HALF)) begin
            rdata_d[DATA_W-1:HALF_W] = signed_q ? {(DATA_W-HALF_W){rdata_d[HALF_W-1]}}
                                                : '0;
          end
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
        end else begin
          idx_d      = idx_nx_c;
          dm_we_d    = we_q;
          dm_addr_d  = addr_q + ADDR_W'(idx_nx_c);
          dm_size_d  = SZ_BYTE;
          dm_wdata_d = DATA_W'(wdata_q[{idx_nx_c, 3'b000} +: BYTE_W]);
        end
      end
`endif

      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          err_d        = 1'b0;
          rdata_d      = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = rdata_q;
  assign resp_err         = err_q;
  assign dmem_write_en    = dm_we_q;
  assign dmem_sign_extend = dm_sext_q;
  assign dmem_addr        = dm_addr_q;
  assign dmem_size        = dm_size_q;
  assign dmem_write_data  = dm_wdata_q;
  assign dmem_mem_write   = dm_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu: randomized self-checking bench for dmem_lsu with a byte-array
// DMEM model and a transaction-level reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dmem_write_en;
  logic        dmem_sign_extend;
  logic [31:0] dmem_addr;
  logic [1:0]  dmem_size;
  logic [31:0] dmem_write_data;
  logic [31:0] dmem_mem_write;
  logic [31:0] dmem_read_data;

  int checks = 0;
  int errors = 0;

  dmem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .dmem_write_en    (dmem_write_en),
    .dmem_sign_extend (dmem_sign_extend),
    .dmem_addr        (dmem_addr),
    .dmem_size        (dmem_size),
    .dmem_write_data  (dmem_write_data),
    .dmem_mem_write   (dmem_mem_write),
    .dmem_read_data   (dmem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DMEM environment model ----------------
  logic [7:0] mem [logic [31:0]];
  int mem_gen = 0;

  function automatic logic [7:0] mrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  always @(dmem_addr or dmem_size or dmem_sign_extend or mem_gen) begin
    logic [31:0] v;
    v = {mrd(dmem_addr + 32'd3), mrd(dmem_addr + 32'd2), mrd(dmem_addr + 32'd1), mrd(dmem_addr)};
    case (dmem_size)
      2'b00:   v = dmem_sign_extend ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
      2'b01:   v = dmem_sign_extend ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
      default: v = v;
    endcase
    dmem_read_data = v;
  end

  always @(posedge clk) begin
    if (dmem_write_en) begin
      int n;
      n = (dmem_size == 2'b00) ? 1 : (dmem_size == 2'b01) ? 2 : 4;
      for (int i = 0; i < n; i++) mem[dmem_addr + 32'(i)] = dmem_write_data[8*i +: 8];
      mem_gen = mem_gen + 1;
    end
  end

  // ---------------- reference memory ----------------
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] rrd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 8'h00;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // One complete transaction: model, drive, per-cycle compare, response hold.
  task automatic do_req(input logic we, input logic [31:0] a, input logic [1:0] sz,
                        input logic sg, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd_o, output logic err_o);
    logic [31:0] e_rd;
    logic        e_err, mis, split;
    int          n, lat, nb, cyc;
    bit          got;
    logic [31:0] b_addr [4];
    logic [1:0]  b_size [4];
    logic        b_sext [4];
    logic [31:0] b_wd   [4];
    logic        b_wdchk[4];

    n     = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mis   = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    split = mis && !TRAP;
    e_err = (sz == 2'b11) || (mis && TRAP);
    e_rd  = 32'h0;
    nb    = 0;
    lat   = 1;
    if (!e_err) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) e_rd[8*i +: 8] = rrd(a + 32'(i));
        if (sg && n == 1) e_rd = {{24{e_rd[7]}}, e_rd[7:0]};
        if (sg && n == 2) e_rd = {{16{e_rd[15]}}, e_rd[15:0]};
      end
      if (split) begin
        nb  = n;
        lat = n + 1;
        for (int i = 0; i < n; i++) begin
          b_addr[i]  = a + 32'(i);
          b_size[i]  = 2'b00;
          b_sext[i]  = 1'b0;
          b_wd[i]    = {24'h0, wd[8*i +: 8]};
          b_wdchk[i] = we;
        end
      end else begin
        nb         = 1;
        lat        = 2;
        b_addr[0]  = a;
        b_size[0]  = sz;
        b_sext[0]  = sg;
        b_wd[0]    = wd;
        b_wdchk[0] = 1'b1;
      end
    end

    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_size   = sz;
    req_signed = sg;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_addr   = $urandom;
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_wdata  = $urandom;

    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) got = 1'b1;
      if (cyc <= nb) begin
        chk("dmem_we",   32'(dmem_write_en),    32'(we));
        chk("dmem_addr", dmem_addr,             b_addr[cyc-1]);
        chk("dmem_size", 32'(dmem_size),        32'(b_size[cyc-1]));
        chk("dmem_sext", 32'(dmem_sign_extend), 32'(b_sext[cyc-1]));
        if (b_wdchk[cyc-1]) chk("dmem_wdata", dmem_write_data, b_wd[cyc-1]);
      end else begin
        chk("dmem_idle_we",   32'(dmem_write_en), 32'd0);
        chk("dmem_idle_addr", dmem_addr,          32'd0);
      end
      chk("mem_write_mirror", dmem_mem_write, dmem_write_data);
      chk("req_ready_busy",   32'(req_ready),   32'd0);
    end
    if (!got) chk("resp_timeout", 32'd0, 32'd1);
    chk("resp_latency", 32'(cyc),        32'(lat));
    chk("resp_rdata",   resp_rdata,      e_rd);
    chk("resp_err",     32'(resp_err),   32'(e_err));
    rd_o  = resp_rdata;
    err_o = resp_err;

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid",   32'(resp_valid),    32'd1);
      chk("hold_rdata",   resp_rdata,         e_rd);
      chk("hold_err",     32'(resp_err),      32'(e_err));
      chk("hold_ready",   32'(req_ready),     32'd0);
      chk("hold_dmem_we", 32'(dmem_write_en), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("post_valid", 32'(resp_valid), 32'd0);
    chk("post_err",   32'(resp_err),   32'd0);
    chk("post_ready", 32'(req_ready),  32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),        32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid),       32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata,            32'd0);
    chk({tag, "_resp_err"},   32'(resp_err),         32'd0);
    chk({tag, "_dmem_we"},    32'(dmem_write_en),    32'd0);
    chk({tag, "_dmem_sext"},  32'(dmem_sign_extend), 32'd0);
    chk({tag, "_dmem_addr"},  dmem_addr,             32'd0);
    chk({tag, "_dmem_size"},  32'(dmem_size),        32'd0);
    chk({tag, "_dmem_wdata"}, dmem_write_data,       32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] ra;
    logic [1:0]  rs;
    int          sel;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: byte store/load with and without sign extension
    do_req(1'b1, 32'h0, 2'b00, 1'b0, 32'h123456AA, 0, rd, er);
    do_req(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 0, rd, er);
    chk("lit_lb_u", rd, 32'h000000AA);
    do_req(1'b0, 32'h0, 2'b00, 1'b1, 32'h0, 0, rd, er);
    chk("lit_lb_s", rd, 32'hFFFFFFAA);

    // 2: half
    do_req(1'b1, 32'h4, 2'b01, 1'b0, 32'h0000BBCC, 0, rd, er);
    do_req(1'b0, 32'h4, 2'b01, 1'b1, 32'h0, 0, rd, er);
    chk("lit_lh_s", rd, 32'hFFFFBBCC);
    do_req(1'b0, 32'h4, 2'b01, 1'b0, 32'h0, 0, rd, er);
    chk("lit_lh_u", rd, 32'h0000BBCC);

    // 3: aligned word
    do_req(1'b1, 32'h8, 2'b10, 1'b0, 32'h11223344, 0, rd, er);
    do_req(1'b0, 32'h8, 2'b10, 1'b0, 32'h0, 0, rd, er);
    chk("lit_lw", rd, 32'h11223344);

    // 4: misaligned word
    do_req(1'b1, 32'h11, 2'b10, 1'b0, 32'h11223344, 0, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lit_mis_trap_err", 32'(er), 32'd1);
    chk("lit_mis_nowrite",  32'(mrd(32'h11)), 32'h0);
`else
    chk("lit_mis_b0", 32'(mrd(32'h11)), 32'h44);
    chk("lit_mis_b1", 32'(mrd(32'h12)), 32'h33);
    chk("lit_mis_b2", 32'(mrd(32'h13)), 32'h22);
    chk("lit_mis_b3", 32'(mrd(32'h14)), 32'h11);
    do_req(1'b0, 32'h11, 2'b10, 1'b0, 32'h0, 0, rd, er);
    chk("lit_mis_lw", rd, 32'h11223344);
`endif

    // 5: illegal size, response held for 3 cycles
    do_req(1'b1, 32'h20, 2'b11, 1'b0, 32'hDEADBEEF, 3, rd, er);
    chk("lit_illegal_err", 32'(er), 32'd1);
    chk("lit_illegal_nowrite", 32'(mrd(32'h20)), 32'h0);

    // 6: wrap past the top of the address space
    do_req(1'b1, 32'hFFFFFFFE, 2'b10, 1'b0, 32'hA1B2C3D4, 0, rd, er);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("lit_wrap_b0", 32'(mrd(32'hFFFFFFFE)), 32'hD4);
    chk("lit_wrap_b1", 32'(mrd(32'hFFFFFFFF)), 32'hC3);
    chk("lit_wrap_b2", 32'(mrd(32'h00000000)), 32'hB2);
    chk("lit_wrap_b3", 32'(mrd(32'h00000001)), 32'hA1);

    // 6b: reset during the second split byte
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h201;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_wdata  = 32'h5566_7788;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_first_byte_we", 32'(dmem_write_en), 32'd1);
    @(negedge clk);
    chk("rst_second_byte_addr", dmem_addr, 32'h202);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    ref_mem[32'h201] = 8'h88;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_no_resp", 32'(resp_valid), 32'd0);
      chk("midrst_idle",    32'(req_ready),  32'd1);
    end
    chk("midrst_byte0_kept",  32'(mrd(32'h201)), 32'h88);
    chk("midrst_byte1_none",  32'(mrd(32'h202)), 32'h00);
`else
    chk("lit_wrap_trap_err", 32'(er), 32'd1);
`endif

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0) ra = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
      else          ra = 32'($urandom_range(0, 63));
      sel = $urandom_range(0, 9);
      rs  = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge clk);
      do_req(1'($urandom), ra, rs, 1'($urandom), $urandom, int'($urandom_range(0, 3)), rd, er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
